rc4_prga: RTL and testbench

- RC4 pseudo-random generation stage. Sits directly downstream of the KSA block (decrypt) in the lab3 cipher datapath.
- Once KSA has left the scrambled permutation in the shared S BRAM, this block walks the permutation, swaps entries, and XORs each keystream byte with the ciphertext ROM. Results go to the plaintext BRAM.
- Messages are length-prefixed: byte 0 holds the length L (0..255), and bytes 1..L hold the data.

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/rc4_prga.sv | 162 ++++++++++++++++
 tb/tb_rc4_prga.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream (PRGA) stage.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN,
        ST_LEN_WR,
        ST_RD_I,
        ST_RD_J,
        ST_WR_I,
        ST_WR_J,
        ST_RD_K,
        ST_WR_PT,
        ST_DONE
    } prga_state_t;

    localparam byte_t MSG_LEN_ADDR    = 8'h00;
    localparam int    CYCLES_PER_BYTE = 6;

endpackage

// File: rtl/rc4_prga.sv
// RC4 PRGA: walks the KSA-scrambled S BRAM, swaps entries and XORs the keystream with the ciphertext ROM.
// Optional RC4_DROP_EN: discard the first DROP_N keystream bytes (RC4-drop[N]) before decrypting.
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | ready, waiting for en
// LEN       | address ciphertext byte 0 (message length)
// LEN_WR    | latch L, copy it to pt[0], clear i/j, k=1
// RD_I      | i+1, read S[i]
// RD_J      | latch si, j+=si, read S[j]
// WR_I      | latch sj, S[i]=sj
// WR_J      | S[j]=si
// RD_K      | read S[si+sj] and ct[k]
// WR_PT     | pt[k] = keystream ^ ct[k]
// DONE      | message finished, back to IDLE next cycle
module rc4_prga
    import rc4_pkg::*;
#(
    parameter int DROP_N = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    output logic [7:0] s_din,
    output logic       s_wren,
    input  logic [7:0] s_dout,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_dout,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_din,
    output logic       pt_wren
);

    if (DROP_N < 0 || DROP_N > 65535) begin : g_drop_range
        $error("DROP_N out of range 0..65535");
    end

    prga_state_t state;
    byte_t i, j, k, si, sj, len;

`ifdef RC4_DROP_EN
    localparam logic [15:0] DROP_INIT = 16'(DROP_N);
    logic [15:0] drop_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
            len   <= '0;
`ifdef RC4_DROP_EN
            drop_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE:   if (en) state <= ST_LEN;
                ST_LEN:    state <= ST_LEN_WR;
                ST_LEN_WR: begin
                    len <= ct_dout;
                    i   <= '0;
                    j   <= '0;
                    k   <= 8'd1;
`ifdef RC4_DROP_EN
                    drop_cnt <= DROP_INIT;
                    if (DROP_INIT != 16'd0)
                        state <= ST_RD_I;
                    else
                        state <= (ct_dout == 8'd0) ? ST_DONE : ST_RD_I;
`else
                    state <= (ct_dout == 8'd0) ? ST_DONE : ST_RD_I;
`endif
                end
                ST_RD_I: begin
                    i     <= i + 8'd1;
                    state <= ST_RD_J;
                end
                ST_RD_J: begin
                    si    <= s_dout;
                    j     <= j + s_dout;
                    state <= ST_WR_I;
                end
                ST_WR_I: begin
                    sj    <= s_dout;
                    state <= ST_WR_J;
                end
                ST_WR_J:   state <= ST_RD_K;
                ST_RD_K: begin
`ifdef RC4_DROP_EN
                    // Drop iterations share the swap path but skip the pt write.
                    if (drop_cnt != 16'd0) begin
                        drop_cnt <= drop_cnt - 16'd1;
                        if (drop_cnt == 16'd1 && len == 8'd0)
                            state <= ST_DONE;
                        else
                            state <= ST_RD_I;
                    end else begin
                        state <= ST_WR_PT;
                    end
`else
                    state <= ST_WR_PT;
`endif
                end
                ST_WR_PT: begin
                    k     <= k + 8'd1;
                    state <= (k == len) ? ST_DONE : ST_RD_I;
                end
                ST_DONE:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign rdy = (state == ST_IDLE);

    // RD_J and WR_I forward s_dout directly so no extra read cycle is needed.
    always_comb begin
        s_addr  = '0;
        s_din   = '0;
        s_wren  = 1'b0;
        ct_addr = '0;
        pt_addr = '0;
        pt_din  = '0;
        pt_wren = 1'b0;
        case (state)
            ST_LEN:    ct_addr = MSG_LEN_ADDR;
            ST_LEN_WR: begin
                pt_addr = MSG_LEN_ADDR;
                pt_din  = ct_dout;
                pt_wren = 1'b1;
            end
            ST_RD_I:   s_addr = i + 8'd1;
            ST_RD_J:   s_addr = j + s_dout;
            ST_WR_I: begin
                s_addr = i;
                s_din  = s_dout;
                s_wren = 1'b1;
            end
            ST_WR_J: begin
                s_addr = j;
                s_din  = si;
                s_wren = 1'b1;
            end
            ST_RD_K: begin
                s_addr  = si + sj;
                ct_addr = k;
            end
            ST_WR_PT: begin
                pt_addr = k;
                pt_din  = s_dout ^ ct_dout;
                pt_wren = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga.sv
// Directed bench for rc4_prga with behavioural S/ct/pt memories; define RC4_DROP_EN to exercise drop3.
module tb_rc4_prga;
    import rc4_pkg::*;

`ifdef RC4_DROP_EN
    localparam int DROP = 3;
`else
    localparam int DROP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_din, s_dout, ct_addr, ct_dout, pt_addr, pt_din;
    logic       s_wren, pt_wren;

    byte_t s_mem [256];
    byte_t s_init[256];
    byte_t ct_mem[256];
    byte_t pt_mem[256];
    byte_t exp_pt[256];
    byte_t s_q, ct_q;
    logic  load_s = 1'b0;
    logic  clr_pt = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rc4_prga #(.DROP_N(DROP)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .rdy     (rdy),
        .s_addr  (s_addr),
        .s_din   (s_din),
        .s_wren  (s_wren),
        .s_dout  (s_dout),
        .ct_addr (ct_addr),
        .ct_dout (ct_dout),
        .pt_addr (pt_addr),
        .pt_din  (pt_din),
        .pt_wren (pt_wren)
    );

    always @(posedge clk) begin
        if (load_s) s_mem <= s_init;
        else if (s_wren) s_mem[s_addr] <= s_din;
        s_q  <= s_mem[s_addr];
        ct_q <= ct_mem[ct_addr];
        if (clr_pt) pt_mem <= '{default: 8'h00};
        else if (pt_wren) pt_mem[pt_addr] <= pt_din;
    end

    assign s_dout  = s_q;
    assign ct_dout = ct_q;

    task automatic ksa(input byte_t key[4], input int klen);
        byte_t jj, t;
        for (int n = 0; n < 256; n++) s_init[n] = byte_t'(n);
        jj = 8'd0;
        for (int n = 0; n < 256; n++) begin
            jj = jj + s_init[n] + key[n % klen];
            t = s_init[n]; s_init[n] = s_init[jj]; s_init[jj] = t;
        end
    endtask

    // Software RC4(-drop) reference built from s_init and ct_mem.
    task automatic model_prga(input int drop);
        byte_t sm[256];
        byte_t ii, jj, t;
        int    len;
        sm = s_init;
        len = int'(ct_mem[0]);
        exp_pt[0] = ct_mem[0];
        ii = 8'd0; jj = 8'd0;
        for (int n = 0; n < drop + len; n++) begin
            ii = ii + 8'd1;
            jj = jj + sm[ii];
            t = sm[ii]; sm[ii] = sm[jj]; sm[jj] = t;
            if (n >= drop) exp_pt[n - drop + 1] = ct_mem[n - drop + 1] ^ sm[byte_t'(sm[ii] + sm[jj])];
        end
    endtask

    task automatic load_mems;
        @(negedge clk); load_s = 1'b1; clr_pt = 1'b1;
        @(negedge clk); load_s = 1'b0; clr_pt = 1'b0;
    endtask

    // Starts one message and counts cycles until rdy returns, plus write pulses seen on the way.
    task automatic run_msg(input bit spam, output int cyc, output int n_s, output int n_pt);
        cyc = 0; n_s = 0; n_pt = 0;
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1; en = spam;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (s_wren) n_s++;
            if (pt_wren) n_pt++;
            en = spam && !rdy;
        end while (!rdy && cyc < 3000);
        en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%0b exp=1", rdy); end
        total++; if (s_wren !== 1'b0) begin bad++; $display("FAIL reset_s_wren got=%0b exp=0", s_wren); end
        total++; if (pt_wren !== 1'b0) begin bad++; $display("FAIL reset_pt_wren got=%0b exp=0", pt_wren); end
        total++; if ({s_addr, s_din, ct_addr, pt_addr, pt_din} !== 40'h0) begin
            bad++; $display("FAIL reset_outputs got=%0h exp=0", {s_addr, s_din, ct_addr, pt_addr, pt_din});
        end
        @(negedge clk); rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_release_rdy got=%0b exp=1", rdy); end
    endtask

    task automatic test_key;
        byte_t key[4] = '{8'h4B, 8'h65, 8'h79, 8'h00};
        byte_t ct[10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        byte_t pt[10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        int cyc, n_s, n_pt;
        ksa(key, 3);
        for (int n = 0; n < 10; n++) ct_mem[n] = ct[n];
`ifdef RC4_DROP_EN
        model_prga(DROP);
`else
        for (int n = 0; n < 10; n++) exp_pt[n] = pt[n];
`endif
        load_mems();
        run_msg(1'b0, cyc, n_s, n_pt);
        total++; if (cyc !== 57 + 5 * DROP) begin bad++; $display("FAIL key_latency got=%0d exp=%0d", cyc, 57 + 5 * DROP); end
        total++; if (n_pt !== 10) begin bad++; $display("FAIL key_pt_wren got=%0d exp=10", n_pt); end
        total++; if (n_s !== 2 * (9 + DROP)) begin bad++; $display("FAIL key_s_wren got=%0d exp=%0d", n_s, 2 * (9 + DROP)); end
        for (int n = 0; n < 10; n++) begin
            total++;
            if (pt_mem[n] !== exp_pt[n]) begin bad++; $display("FAIL key_pt[%0d] got=%02h exp=%02h", n, pt_mem[n], exp_pt[n]); end
        end
    endtask

    task automatic check_perm(input string tag);
        bit seen[256];
        int cnt = 0;
        for (int n = 0; n < 256; n++) seen[n] = 1'b0;
        for (int n = 0; n < 256; n++) if (!seen[s_mem[n]]) begin seen[s_mem[n]] = 1'b1; cnt++; end
        total++; if (cnt !== 256) begin bad++; $display("FAIL %s_perm got=%0d distinct exp=256", tag, cnt); end
    endtask

    task automatic run_wiki(input bit spam, input string tag);
        byte_t key[4] = '{8'h57, 8'h69, 8'h6B, 8'h69};
        byte_t ct[6] = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
        byte_t pt[6] = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
        int cyc, n_s, n_pt;
        ksa(key, 4);
        for (int n = 0; n < 6; n++) ct_mem[n] = ct[n];
`ifdef RC4_DROP_EN
        model_prga(DROP);
`else
        for (int n = 0; n < 6; n++) exp_pt[n] = pt[n];
`endif
        load_mems();
        run_msg(spam, cyc, n_s, n_pt);
        total++; if (cyc !== 33 + 5 * DROP) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", tag, cyc, 33 + 5 * DROP); end
        total++; if (n_pt !== 6) begin bad++; $display("FAIL %s_pt_wren got=%0d exp=6", tag, n_pt); end
        for (int n = 0; n < 6; n++) begin
            total++;
            if (pt_mem[n] !== exp_pt[n]) begin bad++; $display("FAIL %s_pt[%0d] got=%02h exp=%02h", tag, n, pt_mem[n], exp_pt[n]); end
        end
        check_perm(tag);
    endtask

    task automatic test_wiki;
        run_wiki(1'b0, "wiki");
    endtask

    task automatic test_len_zero;
        int cyc, n_s, n_pt;
        for (int n = 0; n < 256; n++) s_init[n] = byte_t'(255 - n);
        ct_mem[0] = 8'h00;
        ct_mem[1] = 8'h5A;
        load_mems();
        run_msg(1'b0, cyc, n_s, n_pt);
        total++; if (cyc !== 3 + 5 * DROP) begin bad++; $display("FAIL len0_latency got=%0d exp=%0d", cyc, 3 + 5 * DROP); end
        total++; if (n_s !== 2 * DROP) begin bad++; $display("FAIL len0_s_wren got=%0d exp=%0d", n_s, 2 * DROP); end
        total++; if (n_pt !== 1) begin bad++; $display("FAIL len0_pt_wren got=%0d exp=1", n_pt); end
        total++; if (pt_mem[0] !== 8'h00) begin bad++; $display("FAIL len0_pt0 got=%02h exp=00", pt_mem[0]); end
        total++; if (pt_mem[1] !== 8'h00) begin bad++; $display("FAIL len0_pt1 got=%02h exp=00", pt_mem[1]); end
    endtask

    task automatic test_len_max;
        int cyc, n_s, n_pt;
        for (int n = 0; n < 256; n++) s_init[n] = byte_t'(n);
        ct_mem[0] = 8'hFF;
        for (int n = 1; n < 256; n++) ct_mem[n] = byte_t'($urandom_range(0, 255));
        model_prga(DROP);
        load_mems();
        run_msg(1'b0, cyc, n_s, n_pt);
        total++; if (cyc !== 3 + 6 * 255 + 5 * DROP) begin bad++; $display("FAIL len255_latency got=%0d exp=%0d", cyc, 3 + 6 * 255 + 5 * DROP); end
        total++; if (n_pt !== 256) begin bad++; $display("FAIL len255_pt_wren got=%0d exp=256", n_pt); end
        for (int n = 0; n < 256; n++) begin
            total++;
            if (pt_mem[n] !== exp_pt[n]) begin bad++; $display("FAIL len255_pt[%0d] got=%02h exp=%02h", n, pt_mem[n], exp_pt[n]); end
        end
        check_perm("len255");
    endtask

    task automatic test_reset_mid;
        byte_t key[4] = '{8'h4B, 8'h65, 8'h79, 8'h00};
        byte_t ct[10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        int cyc, n_s, n_pt;
        ksa(key, 3);
        for (int n = 0; n < 10; n++) ct_mem[n] = ct[n];
        model_prga(DROP);
        load_mems();
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        repeat (17 + 5 * DROP) @(posedge clk);
        #1;
        total++; if (s_wren !== 1'b1) begin bad++; $display("FAIL midrst_in_wr_j got=%0b exp=1", s_wren); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL midrst_rdy got=%0b exp=1", rdy); end
        total++; if ({s_wren, pt_wren} !== 2'b00) begin bad++; $display("FAIL midrst_wren got=%02b exp=00", {s_wren, pt_wren}); end
        rst = 1'b0;
        load_mems();
        run_msg(1'b0, cyc, n_s, n_pt);
        total++; if (cyc !== 57 + 5 * DROP) begin bad++; $display("FAIL midrst_rerun_latency got=%0d exp=%0d", cyc, 57 + 5 * DROP); end
        for (int n = 0; n < 10; n++) begin
            total++;
            if (pt_mem[n] !== exp_pt[n]) begin bad++; $display("FAIL midrst_pt[%0d] got=%02h exp=%02h", n, pt_mem[n], exp_pt[n]); end
        end
    endtask

    task automatic test_en_spam;
        run_wiki(1'b1, "spam");
        @(posedge clk); #1;
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL spam_no_requeue got=%0b exp=1", rdy); end
    endtask

    initial begin
        test_reset();
        test_key();
        test_wiki();
        test_len_zero();
        test_len_max();
        test_reset_mid();
        test_en_spam();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
